// File: rtl/click_decoder.sv
// Click burst decoder: counts debounced presses until a quiet gap of WINDOW cycles, then holds the count for a ready/valid consumer.
// Optional drop counter for presses discarded while an event is pending: define CLICK_DROP_CNT_EN.
module click_decoder #(
  parameter int unsigned WINDOW = 25000000,
  parameter int unsigned CW     = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          db_tick,
  input  logic          ev_ready,
  output logic          ev_valid,
  output logic [CW-1:0] ev_count,
  output logic          busy
`ifdef CLICK_DROP_CNT_EN
  ,
  output logic [7:0]    drop_cnt
`endif
);

  localparam int unsigned     TW         = $clog2(WINDOW);
  localparam logic [TW-1:0]   TIMER_LOAD = TW'(WINDOW - 1);
  localparam logic [CW-1:0]   CNT_MAX    = '1;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    HOLD
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          ev_valid_q, ev_valid_d;
  logic [CW-1:0] ev_count_q, ev_count_d;
  logic          busy_q, busy_d;
`ifdef CLICK_DROP_CNT_EN
  logic [7:0]    drop_q, drop_d;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      count_q    <= '0;
      timer_q    <= '0;
      ev_valid_q <= 1'b0;
      ev_count_q <= '0;
      busy_q     <= 1'b0;
`ifdef CLICK_DROP_CNT_EN
      drop_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      timer_q    <= timer_d;
      ev_valid_q <= ev_valid_d;
      ev_count_q <= ev_count_d;
      busy_q     <= busy_d;
`ifdef CLICK_DROP_CNT_EN
      drop_q     <= drop_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    timer_d    = timer_q;
    ev_valid_d = ev_valid_q;
    ev_count_d = ev_count_q;
`ifdef CLICK_DROP_CNT_EN
    drop_d     = drop_q;
`endif
    case (state_q)
      IDLE: begin
        if (db_tick) begin
          state_d = COLLECT;
          count_d = CW'(1);
          timer_d = TIMER_LOAD;
        end
      end
      COLLECT: begin
        // A tick on the timer==0 cycle still extends the burst.
        if (db_tick) begin
          if (count_q != CNT_MAX) count_d = count_q + 1'b1;
          timer_d = TIMER_LOAD;
        end else if (timer_q != '0) begin
          timer_d = timer_q - 1'b1;
        end else begin
          state_d    = HOLD;
          ev_count_d = count_q;
          ev_valid_d = 1'b1;
        end
      end
      HOLD: begin
        if (ev_valid_q && ev_ready) begin
          ev_valid_d = 1'b0;
          if (db_tick) begin
            state_d = COLLECT;
            count_d = CW'(1);
            timer_d = TIMER_LOAD;
          end else begin
            state_d = IDLE;
            count_d = '0;
          end
        end else if (db_tick) begin
`ifdef CLICK_DROP_CNT_EN
          if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  assign ev_valid = ev_valid_q;
  assign ev_count = ev_count_q;
  assign busy     = busy_q;
`ifdef CLICK_DROP_CNT_EN
  assign drop_cnt = drop_q;
`endif

endmodule

// File: tb/tb_click_decoder.sv
// Directed self-checking bench for click_decoder with WINDOW=8, CW=3.
module tb_click_decoder;

  localparam int unsigned WINDOW = 8;
  localparam int unsigned CW     = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          db_tick;
  logic          ev_ready;
  logic          ev_valid;
  logic [CW-1:0] ev_count;
  logic          busy;
`ifdef CLICK_DROP_CNT_EN
  logic [7:0]    drop_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  click_decoder #(.WINDOW(WINDOW), .CW(CW)) dut (
    .clk      (clk),
    .reset    (reset),
    .db_tick  (db_tick),
    .ev_ready (ev_ready),
    .ev_valid (ev_valid),
    .ev_count (ev_count),
    .busy     (busy)
`ifdef CLICK_DROP_CNT_EN
    ,
    .drop_cnt (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive inputs, take one rising edge, then settle 1 time unit past it.
  task automatic step(input logic tick, input logic rdy);
    db_tick  = tick;
    ev_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset    = 1'b1;
    db_tick  = 1'b0;
    ev_ready = 1'b0;
    #23;
    chk("rst_valid", 32'(ev_valid), 32'd0);
    chk("rst_count", 32'(ev_count), 32'd0);
    chk("rst_busy",  32'(busy),     32'd0);
`ifdef CLICK_DROP_CNT_EN
    chk("rst_drop",  32'(drop_cnt), 32'd0);
`endif
    @(negedge clk);
    reset = 1'b0;
    step(1'b0, 1'b1);
    chk("idle_ready_ignored", 32'(busy), 32'd0);

    // Single tick, ready held high.
    step(1'b1, 1'b1);
    chk("t1_busy", 32'(busy), 32'd1);
    for (int e = 1; e <= 8; e++) begin
      step(1'b0, 1'b1);
      chk("t1_valid", 32'(ev_valid), 32'(e == 8));
    end
    chk("t1_count", 32'(ev_count), 32'd1);
    step(1'b0, 1'b1);
    chk("t1_drop_valid", 32'(ev_valid), 32'd0);
    chk("t1_idle", 32'(busy), 32'd0);

    // Ticks at edges 0,3,9; event held 20 cycles without ready.
    for (int e = 0; e <= 17; e++) begin
      step(logic'(e == 0 || e == 3 || e == 9), 1'b0);
      chk("t2_valid", 32'(ev_valid), 32'(e == 17));
    end
    chk("t2_count", 32'(ev_count), 32'd3);
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b0);
      chk("t2_hold_valid", 32'(ev_valid), 32'd1);
      chk("t2_hold_count", 32'(ev_count), 32'd3);
    end
    step(1'b0, 1'b1);
    chk("t2_accept", 32'(ev_valid), 32'd0);
    chk("t2_idle", 32'(busy), 32'd0);

    // Nine ticks two cycles apart saturate the count.
    for (int e = 0; e <= 24; e++) begin
      step(logic'((e % 2 == 0) && e <= 16), 1'b0);
      chk("t3_valid", 32'(ev_valid), 32'(e == 24));
    end
    chk("t3_count", 32'(ev_count), 32'd7);

    // Ticks in HOLD without acceptance are dropped; accept with tick restarts.
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    chk("t4_hold_valid", 32'(ev_valid), 32'd1);
    chk("t4_hold_count", 32'(ev_count), 32'd7);
`ifdef CLICK_DROP_CNT_EN
    chk("t4_drop", 32'(drop_cnt), 32'd2);
`endif
    step(1'b1, 1'b1);
    chk("t4_restart_valid", 32'(ev_valid), 32'd0);
    chk("t4_restart_busy", 32'(busy), 32'd1);
    for (int e = 1; e <= 8; e++) begin
      step(1'b0, 1'b0);
      chk("t4_valid", 32'(ev_valid), 32'(e == 8));
    end
    chk("t4_count", 32'(ev_count), 32'd1);
    step(1'b0, 1'b1);
    chk("t4_accept", 32'(ev_valid), 32'd0);

    // Reset mid-burst discards it; first tick afterwards works.
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    reset = 1'b1;
    #1;
    chk("t5_async_busy", 32'(busy), 32'd0);
    step(1'b0, 1'b0);
    reset = 1'b0;
`ifdef CLICK_DROP_CNT_EN
    chk("t5_drop_clr", 32'(drop_cnt), 32'd0);
`endif
    for (int e = 5; e <= 18; e++) begin
      step(logic'(e == 10), 1'b0);
      chk("t5_valid", 32'(ev_valid), 32'(e == 18));
    end
    chk("t5_count", 32'(ev_count), 32'd1);
    step(1'b0, 1'b1);

    // Ticks exactly WINDOW apart merge into one burst.
    for (int e = 0; e <= 16; e++) begin
      step(logic'(e == 0 || e == 8), 1'b0);
      chk("t6_valid", 32'(ev_valid), 32'(e == 16));
    end
    chk("t6_count", 32'(ev_count), 32'd2);
    step(1'b0, 1'b1);
    chk("t6_accept", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
